// File: rtl/sp_ram_adapter_pkg.sv
// Sizing helpers shared by the single-port RAM request adapter and its response FIFO.
package sp_ram_adapter_pkg;

  // Read latency of the RAM instance: one array cycle plus the optional output register.
  function automatic int unsigned rd_latency(input int unsigned out_regs);
    return 32'd1 + out_regs;
  endfunction

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer addressing depth entries; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// Read-response FIFO: circular storage with wrap-at-DEPTH pointers and an occupancy
// counter, so non-power-of-two depths work. No bypass: a push becomes visible next cycle.
module sp_ram_rsp_fifo
  import sp_ram_adapter_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            Clk_CI,
  input  logic                            Rst_RBI,
  input  logic                            push,
  input  logic [DATA_WIDTH-1:0]           push_data,
  input  logic                            pop,
  output logic [DATA_WIDTH-1:0]           pop_data,
  output logic                            empty,
  output logic                            full,
  output logic [cnt_width(DEPTH)-1:0]     count
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Storage: cleared on reset so the data output reads zero until the first push.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers advance independently and wrap from DEPTH-1 back to 0.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Credits upstream make overflow/underflow impossible; flag it if it ever happens.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RBI) begin
      assert (!(push && full))  else $error("sp_ram_rsp_fifo: push while full");
      assert (!(pop && empty))  else $error("sp_ram_rsp_fifo: pop while empty");
    end
  end

endmodule

// File: rtl/sp_ram_req_adapter.sv
// Valid/ready front end for the synchronous single-port RAM. Requests drive the RAM
// port combinationally in the accept cycle; reads are tracked through an L-deep tag
// pipe and their data lands in a credit-protected response FIFO, so nothing is dropped.
module sp_ram_req_adapter
  import sp_ram_adapter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_REGS   = 0,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWrEn_SI,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [DATA_WIDTH-1:0] ReqWrData_DI,
  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic [DATA_WIDTH-1:0] RspRdData_DO,
  output logic                  RamCSel_SO,
  output logic                  RamWrEn_SO,
  output logic [ADDR_WIDTH-1:0] RamAddr_DO,
  output logic [DATA_WIDTH-1:0] RamWrData_DO,
  input  logic [DATA_WIDTH-1:0] RamRdData_DI
);

  localparam int unsigned LAT = rd_latency(OUT_REGS);
  localparam int unsigned CW  = cnt_width(RSP_DEPTH);

  logic          en_q;
  logic [CW-1:0] credits_q;
  logic [LAT-1:0] tag_q;
  logic          xfer;
  logic          rd_accept;
  logic          rsp_pop;
  logic          push;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

  // Ready depends only on registers: a credit guarantees FIFO room when the read lands.
  assign ReqReady_SO = en_q & (credits_q != '0);
  assign xfer        = ReqValid_SI & ReqReady_SO;
  assign rd_accept   = xfer & ~ReqWrEn_SI;
  assign rsp_pop     = RspValid_SO & RspReady_SI;
  assign push        = tag_q[LAT-1];
  assign RspValid_SO = ~fifo_empty;

  assign RamCSel_SO   = xfer;
  assign RamWrEn_SO   = ReqWrEn_SI;
  assign RamAddr_DO   = ReqAddr_DI;
  assign RamWrData_DO = ReqWrData_DI;

  // Enable rises one clock after reset release so the RAM sees a quiet first cycle.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) en_q <= 1'b0;
    else          en_q <= 1'b1;
  end

  // Credits: taken by a read accept, returned by a response pop.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      credits_q <= CW'(RSP_DEPTH);
    end else begin
      case ({rd_accept, rsp_pop})
        2'b10:   credits_q <= credits_q - CW'(1);
        2'b01:   credits_q <= credits_q + CW'(1);
        default: credits_q <= credits_q;
      endcase
    end
  end

  // Tag pipe: a set bit in the top stage means RamRdData_DI is valid this cycle.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) tag_q <= '0;
    else          tag_q <= (tag_q << 1) | LAT'(rd_accept);
  end

  sp_ram_rsp_fifo #(
    .DEPTH      (RSP_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .Clk_CI    (Clk_CI),
    .Rst_RBI   (Rst_RBI),
    .push      (push),
    .push_data (RamRdData_DI),
    .pop       (rsp_pop),
    .pop_data  (RspRdData_DO),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Parameter sanity and credit conservation, checked in simulation on every clock.
  always_ff @(posedge Clk_CI) begin
    assert (OUT_REGS <= 1) else $error("sp_ram_req_adapter: OUT_REGS must be 0 or 1");
    assert (RSP_DEPTH >= 2) else $error("sp_ram_req_adapter: RSP_DEPTH must be >= 2");
    if (Rst_RBI) begin
      assert (int'(credits_q) + $countones(tag_q) + int'(fifo_count) == int'(RSP_DEPTH))
        else $error("sp_ram_req_adapter: credit invariant broken");
      assert (!(push && fifo_full)) else $error("sp_ram_req_adapter: response push while full");
    end
  end

endmodule

// File: tb/tb_sp_ram_req_adapter.sv
// Directed bench: DUT0 (OUT_REGS=0, RSP_DEPTH=4) and DUT1 (OUT_REGS=1, RSP_DEPTH=3),
// each in front of a behavioural RAM preloaded with mem[a] = base + a.
module tb_sp_ram_req_adapter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cur      = 0;

  logic v0 = 0, we0 = 0, rr0 = 0;
  logic [9:0]  a0 = '0;
  logic [31:0] d0 = '0;
  logic ready0, rv0, csel0, rwe0;
  logic [9:0]  raddr0;
  logic [31:0] rdata0, rwd0, ramrd0;

  logic v1 = 0, we1 = 0, rr1 = 0;
  logic [9:0]  a1 = '0;
  logic [31:0] d1 = '0;
  logic ready1, rv1, csel1, rwe1;
  logic [9:0]  raddr1;
  logic [31:0] rdata1, rwd1, ramrd1;

  sp_ram_req_adapter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REGS(0), .RSP_DEPTH(4)) u_dut0 (
    .Clk_CI(clk), .Rst_RBI(rst),
    .ReqValid_SI(v0), .ReqReady_SO(ready0), .ReqWrEn_SI(we0), .ReqAddr_DI(a0), .ReqWrData_DI(d0),
    .RspValid_SO(rv0), .RspReady_SI(rr0), .RspRdData_DO(rdata0),
    .RamCSel_SO(csel0), .RamWrEn_SO(rwe0), .RamAddr_DO(raddr0), .RamWrData_DO(rwd0),
    .RamRdData_DI(ramrd0));

  sp_ram_req_adapter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REGS(1), .RSP_DEPTH(3)) u_dut1 (
    .Clk_CI(clk), .Rst_RBI(rst),
    .ReqValid_SI(v1), .ReqReady_SO(ready1), .ReqWrEn_SI(we1), .ReqAddr_DI(a1), .ReqWrData_DI(d1),
    .RspValid_SO(rv1), .RspReady_SI(rr1), .RspRdData_DO(rdata1),
    .RamCSel_SO(csel1), .RamWrEn_SO(rwe1), .RamAddr_DO(raddr1), .RamWrData_DO(rwd1),
    .RamRdData_DI(ramrd1));

  // RAM models: one-cycle array read; DUT1's RAM adds an output register.
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] rd0  = '0;
  logic [31:0] rd1a = '0;
  logic [31:0] rd1b = '0;

  always @(posedge clk) begin
    if (csel0) begin
      if (rwe0) mem0[raddr0] = rwd0;
      else      rd0 <= mem0[raddr0];
    end
  end

  always @(posedge clk) begin
    if (csel1) begin
      if (rwe1) mem1[raddr1] = rwd1;
      else      rd1a <= mem1[raddr1];
    end
    rd1b <= rd1a;
  end

  assign ramrd0 = rd0;
  assign ramrd1 = rd1b;

  // Outputs of whichever DUT is currently under test.
  logic o_ready, o_rv, o_csel;
  logic [31:0] o_data;
  always_comb begin
    o_ready = ready0; o_rv = rv0; o_csel = csel0; o_data = rdata0;
    if (cur == 1) begin
      o_ready = ready1; o_rv = rv1; o_csel = csel1; o_data = rdata1;
    end
  end

  typedef struct {
    logic        v;
    logic        we;
    logic [9:0]  a;
    logic [31:0] d;
    logic        e_ready;
    logic        e_rv;
    logic        e_csel;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  typedef struct {
    logic        we;
    logic [9:0]  a;
    logic [31:0] d;
  } req_t;

  vec_t        tbl [24];
  req_t        q_req [$];
  logic [31:0] q_exp [$];

  function automatic vec_t mk(input logic v, input logic we, input logic [9:0] a,
                              input logic [31:0] d, input logic er, input logic erv,
                              input logic ecs, input logic cd, input logic [31:0] ed);
    vec_t t;
    t.v = v; t.we = we; t.a = a; t.d = d;
    t.e_ready = er; t.e_rv = erv; t.e_csel = ecs; t.chk_data = cd; t.e_data = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, outputs are sampled 1 ns later.
  task automatic drive(input logic v, input logic we, input logic [9:0] a,
                       input logic [31:0] d, input logic rr);
    @(negedge clk);
    if (cur == 0) begin v0 = v; we0 = we; a0 = a; d0 = d; rr0 = rr; end
    else          begin v1 = v; we1 = we; a1 = a; d1 = d; rr1 = rr; end
    #1;
  endtask

  function automatic req_t rd(input int a);
    req_t r;
    r.we = 1'b0; r.a = 10'(a); r.d = '0;
    return r;
  endfunction

  // Offer queued requests (held until accepted) for ncyc cycles; check popped responses.
  task automatic run(input logic rr, input int ncyc, output int nacc);
    int  idx;
    logic v;
    idx  = 0;
    nacc = 0;
    for (int c = 0; c < ncyc; c++) begin
      v = (idx < q_req.size());
      if (v) drive(1'b1, q_req[idx].we, q_req[idx].a, q_req[idx].d, rr);
      else   drive(1'b0, 1'b0, '0, '0, rr);
      if (rr && o_rv) begin
        if (q_exp.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected got=%h want=no_response", o_data);
        end else begin
          chk("rsp_data", o_data, q_exp.pop_front());
        end
      end
      if (v && o_ready) begin
        idx++;
        nacc++;
      end
    end
    for (int k = 0; k < idx; k++) void'(q_req.pop_front());
  endtask

  initial begin
    int n;

    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'h100 + 32'(i);
      mem1[i] = 32'h200 + 32'(i);
    end

    tbl[0] = mk(0, 0, 10'd0, 32'd0, 0, 0, 0, 1, 32'd0);
    for (int r = 1; r <= 16; r++)
      tbl[r] = mk(1, 0, 10'(r - 1), 32'd0, 1, r >= 3, 1, r >= 3, 32'h100 + 32'(r - 3));
    tbl[17] = mk(0, 0, 10'd0, 32'd0, 1, 1, 0, 1, 32'h10E);
    tbl[18] = mk(0, 0, 10'd0, 32'd0, 1, 1, 0, 1, 32'h10F);
    tbl[19] = mk(1, 1, 10'd3, 32'hDEADBEEF, 1, 0, 1, 0, 32'd0);
    tbl[20] = mk(1, 0, 10'd3, 32'd0, 1, 0, 1, 0, 32'd0);
    tbl[21] = mk(0, 0, 10'd0, 32'd0, 1, 0, 0, 0, 32'd0);
    tbl[22] = mk(0, 0, 10'd0, 32'd0, 1, 1, 0, 1, 32'hDEADBEEF);
    tbl[23] = mk(0, 0, 10'd0, 32'd0, 1, 0, 0, 0, 32'd0);

    // Held in reset with a request offered: RAM stays deselected, outputs at reset values.
    repeat (2) @(negedge clk);
    v0 = 1'b1;
    #1;
    chk("rst_csel", 32'(csel0), 32'd0);
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_rv", 32'(rv0), 32'd0);
    chk("rst_data", rdata0, 32'd0);
    v0 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;

    // Table: idle after release, 16 back-to-back reads, write then read-after-write.
    for (int r = 0; r < 24; r++) begin
      drive(tbl[r].v, tbl[r].we, tbl[r].a, tbl[r].d, 1'b1);
      chk($sformatf("row%0d_ready", r), 32'(o_ready), 32'(tbl[r].e_ready));
      chk($sformatf("row%0d_rv", r), 32'(o_rv), 32'(tbl[r].e_rv));
      chk($sformatf("row%0d_csel", r), 32'(o_csel), 32'(tbl[r].e_csel));
      if (tbl[r].chk_data) chk($sformatf("row%0d_data", r), o_data, tbl[r].e_data);
      if (tbl[r].e_csel) begin
        chk($sformatf("row%0d_ram_we", r), 32'(rwe0), 32'(tbl[r].we));
        chk($sformatf("row%0d_ram_addr", r), 32'(raddr0), 32'(tbl[r].a));
        if (tbl[r].we) chk($sformatf("row%0d_ram_wdata", r), rwd0, tbl[r].d);
      end
    end

    // Backpressure: four reads take all credits, then a pending write stalls too.
    for (int i = 0; i < 4; i++) q_req.push_back(rd(i));
    q_req.push_back('{we: 1'b1, a: 10'd5, d: 32'hCAFE0005});
    q_req.push_back(rd(4));
    q_req.push_back(rd(5));
    q_exp = '{32'h100, 32'h101, 32'h102, 32'hDEADBEEF, 32'h104, 32'hCAFE0005};
    run(1'b0, 10, n);
    chk("stall_accepts", 32'(n), 32'd4);
    chk("stall_ready", 32'(o_ready), 32'd0);
    chk("stall_wr_csel", 32'(o_csel), 32'd0);
    chk("stall_rv", 32'(o_rv), 32'd1);
    chk("stall_head", o_data, 32'h100);
    run(1'b1, 1, n);
    chk("pop_cycle_accepts", 32'(n), 32'd0);
    run(1'b0, 8, n);
    chk("after_pop_accepts", 32'(n), 32'd2);
    chk("after_pop_ready", 32'(o_ready), 32'd0);
    run(1'b1, 20, n);
    chk("drain_accepts", 32'(n), 32'd1);
    chk("drain_rsp_left", 32'(q_exp.size()), 32'd0);

    // Reset with reads pending and responses queued: nothing stale may reappear.
    for (int i = 6; i <= 8; i++) q_req.push_back(rd(i));
    run(1'b0, 3, n);
    chk("pre_rst_accepts", 32'(n), 32'd3);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("pre_rst_rv", 32'(o_rv), 32'd1);
    chk("pre_rst_data", o_data, 32'h106);
    rst = 1'b0;
    v0  = 1'b1;
    #1;
    chk("mid_rst_csel", 32'(csel0), 32'd0);
    chk("mid_rst_ready", 32'(ready0), 32'd0);
    chk("mid_rst_rv", 32'(rv0), 32'd0);
    chk("mid_rst_data", rdata0, 32'd0);
    v0 = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("rel_c0_ready", 32'(o_ready), 32'd0);
    chk("rel_c0_rv", 32'(o_rv), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("rel_c1_ready", 32'(o_ready), 32'd1);
    chk("rel_c1_rv", 32'(o_rv), 32'd0);
    for (int i = 9; i <= 14; i++) q_req.push_back(rd(i));
    run(1'b0, 10, n);
    chk("rel_credits", 32'(n), 32'd4);
    chk("rel_stall_ready", 32'(o_ready), 32'd0);
    for (int i = 9; i <= 14; i++) q_exp.push_back(32'h100 + 32'(i));
    run(1'b1, 20, n);
    chk("rel_drain_accepts", 32'(n), 32'd2);
    chk("rel_rsp_left", 32'(q_exp.size()), 32'd0);

    // DUT1: read latency of three cycles, then pointer wrap on a depth-3 FIFO.
    cur = 1;
    drive(1'b1, 1'b0, 10'd0, '0, 1'b0);
    chk("l2_accept_ready", 32'(o_ready), 32'd1);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("l2_t1_rv", 32'(o_rv), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("l2_t2_rv", 32'(o_rv), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    chk("l2_t3_rv", 32'(o_rv), 32'd1);
    chk("l2_t3_data", o_data, 32'h200);
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    chk("l2_pop_rv", 32'(o_rv), 32'd1);
    for (int i = 1; i <= 6; i++) begin
      q_req.push_back(rd(i));
      q_exp.push_back(32'h200 + 32'(i));
    end
    run(1'b1, 25, n);
    chk("l2_stream_accepts", 32'(n), 32'd6);
    chk("l2_stream_left", 32'(q_exp.size()), 32'd0);
    for (int i = 7; i <= 10; i++) q_req.push_back(rd(i));
    run(1'b0, 12, n);
    chk("l2_stall_accepts", 32'(n), 32'd3);
    chk("l2_stall_ready", 32'(o_ready), 32'd0);
    for (int i = 7; i <= 10; i++) q_exp.push_back(32'h200 + 32'(i));
    run(1'b1, 20, n);
    chk("l2_drain_accepts", 32'(n), 32'd1);
    chk("l2_drain_left", 32'(q_exp.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
